mux_sel_arbiter: RTL and testbench

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

---
 rtl/mux_sel_arbiter_if.sv | 23 ++
 rtl/mux_sel_arbiter.sv | 118 +++++++++++
 tb/tb_mux_sel_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mux_sel_arbiter_if.sv
// Handshake bundle between two requesters and the 2:1 mux select arbiter.
// The requester side (master) drives requests and done; the arbiter side
// (slave) returns the grant, mux select, busy and timeout indications.
interface mux_sel_arbiter_if;
   logic req0;
   logic req1;
   logic done;
   logic sel;
   logic gnt0;
   logic gnt1;
   logic busy;
   logic timeout;

   modport master (
      output req0, req1, done,
      input  sel, gnt0, gnt1, busy, timeout
   );

   modport slave (
      input  req0, req1, done,
      output sel, gnt0, gnt1, busy, timeout
   );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Two-channel round-robin arbiter that owns the select of a downstream 2:1
// mux. Grants are bounded by MAX_HOLD cycles; a grant that ends purely on
// the hold limit raises a one-cycle timeout pulse. All outputs come straight
// from registers so the mux select never sees a combinational input path.
module mux_sel_arbiter #(
   parameter int MAX_HOLD = 15,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   mux_sel_arbiter_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] GNT0 = 2'd1;
   localparam logic [1:0] GNT1 = 2'd2;

   localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_q, last_d;     // channel of the most recent grant
   logic             sel_q, sel_d;
   logic             timeout_q, timeout_d;

   logic own_req, other_req, at_limit, release_grant;
   logic enter, enter_ch;

   // Qualify the current holder: its own request, the competitor, and the release causes.
   always_comb begin
      own_req       = (state_q == GNT1) ? bus.req1 : bus.req0;
      other_req     = (state_q == GNT1) ? bus.req0 : bus.req1;
      at_limit      = (cnt_q >= HOLD_LIMIT);
      release_grant = bus.done || !own_req || at_limit;
   end

   // Next-state logic: arbitration from IDLE, release/hand-off from a grant.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned; a missing default here would infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      sel_d     = sel_q;
      timeout_d = 1'b0;
      enter     = 1'b0;
      enter_ch  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req0 && bus.req1) begin
               enter    = 1'b1;
               enter_ch = ~last_q;
            end else if (bus.req0) begin
               enter    = 1'b1;
               enter_ch = 1'b0;
            end else if (bus.req1) begin
               enter    = 1'b1;
               enter_ch = 1'b1;
            end
         end
         GNT0, GNT1: begin
            if (release_grant) begin
               // Pulse only when the limit is the sole reason for the release.
               timeout_d = at_limit && own_req && !bus.done;
               if (other_req) begin
                  enter    = 1'b1;
                  enter_ch = (state_q == GNT0);
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Any grant entry restarts the hold count and steers the mux.
      if (enter) begin
         state_d = enter_ch ? GNT1 : GNT0;
         cnt_d   = CNT_ONE;
         last_d  = enter_ch;
         sel_d   = enter_ch;
      end
   end

   // State registers with synchronous reset; channel 0 wins the first tie.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         last_q    <= 1'b1;
         sel_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         sel_q     <= sel_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.gnt0    = (state_q == GNT0);
   assign bus.gnt1    = (state_q == GNT1);
   assign bus.busy    = (state_q != IDLE);
   assign bus.sel     = sel_q;
   assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed and random bench for mux_sel_arbiter with MAX_HOLD = 4.
// A behavioural model predicts {gnt0,gnt1,sel,busy,timeout} for each cycle;
// predictions are queued when inputs are driven and popped after the edge.
module tb_mux_sel_arbiter;

   localparam int MAX_HOLD = 4;
   localparam int CNT_W    = 4;

   logic clk;
   logic rst;

   mux_sel_arbiter_if bus ();

   mux_sel_arbiter #(
      .MAX_HOLD(MAX_HOLD),
      .CNT_W   (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   logic [4:0] sb_q[$];

   // Reference model state: owner -1 means no grant.
   int   m_owner = -1;
   int   m_held  = 0;
   int   m_last  = 1;
   logic m_sel   = 1'b0;
   logic m_to    = 1'b0;

   int wait0 = 0;
   int wait1 = 0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] dut_vec();
      return {bus.gnt0, bus.gnt1, bus.sel, bus.busy, bus.timeout};
   endfunction

   // Advance the model by one edge and return the outputs it predicts.
   task automatic model_next(input logic r0, input logic r1, input logic d,
                             input logic rs, output logic [4:0] exp);
      int   want;
      logic mine, theirs, ending;
      want = -1;
      if (rs) begin
         m_owner = -1; m_held = 0; m_last = 1; m_sel = 1'b0; m_to = 1'b0;
      end else if (m_owner < 0) begin
         m_to = 1'b0;
         if (r0 && r1)  want = (m_last == 1) ? 0 : 1;
         else if (r0)   want = 0;
         else if (r1)   want = 1;
      end else begin
         mine   = (m_owner == 0) ? r0 : r1;
         theirs = (m_owner == 0) ? r1 : r0;
         ending = d || !mine || (m_held >= MAX_HOLD);
         m_to   = ending && (m_held >= MAX_HOLD) && !d && mine;
         if (!ending)      m_held++;
         else if (theirs)  want = 1 - m_owner;
         else              m_owner = -1;
      end
      if (want >= 0) begin
         m_owner = want; m_held = 1; m_last = want; m_sel = (want == 1);
      end
      exp = {m_owner == 0, m_owner == 1, m_sel, m_owner >= 0, m_to};
   endtask

   // Drive one cycle of inputs, queue the prediction, then compare after the edge.
   task automatic step(input logic r0, input logic r1, input logic d, input logic rs);
      logic [4:0] exp;
      bus.req0 = r0;
      bus.req1 = r1;
      bus.done = d;
      rst      = rs;
      model_next(r0, r1, d, rs, exp);
      sb_q.push_back(exp);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check("sb_empty", 8'd0, 8'd1);
      end else begin
         check("scoreboard", {3'b0, dut_vec()}, {3'b0, sb_q.pop_front()});
      end
   endtask

   // Hold-limit run on channel 1 ending with the given last-cycle inputs.
   task automatic hold_run(input string tag, input logic last_r1, input logic last_d,
                           input logic [4:0] end_exp);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check({tag, "_enter"}, {3'b0, dut_vec()}, 8'b000_01110);
      for (int i = 2; i <= MAX_HOLD; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         check({tag, "_hold"}, {3'b0, dut_vec()}, 8'b000_01110);
      end
      step(1'b0, last_r1, last_d, 1'b0);
      check({tag, "_end"}, {3'b0, dut_vec()}, {3'b0, end_exp});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.done = 1'b0;
      rst      = 1'b1;

      // Reset: everything low.
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("reset", {3'b0, dut_vec()}, 8'h00);

      // Single request, grant after one edge, done releases it.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("req0_gnt", {3'b0, dut_vec()}, 8'b000_10010);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("req0_done", {3'b0, dut_vec()}, 8'b000_00000);

      // Tie after reset: channel 0 first, then direct hand-off both ways.
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("tie_first", {3'b0, dut_vec()}, 8'b000_10010);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("tie_handoff1", {3'b0, dut_vec()}, 8'b000_01110);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("tie_handoff0", {3'b0, dut_vec()}, 8'b000_10010);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check("tie_release", {3'b0, dut_vec()}, 8'b000_00000);

      // Pure hold-limit termination: timeout pulse, IDLE, sel stays 1.
      hold_run("limit", 1'b1, 1'b0, 5'b00101);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("timeout_one_cycle", {3'b0, dut_vec()}, 8'b000_00100);

      // Limit coincident with done, then with request drop: no timeout.
      hold_run("limit_done", 1'b1, 1'b1, 5'b00100);
      hold_run("limit_drop", 1'b0, 1'b0, 5'b00100);

      // Reset mid-grant drops everything; held request is re-granted after.
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("pre_rst_gnt1", {3'b0, dut_vec()}, 8'b000_01110);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      check("rst_mid_grant", {3'b0, dut_vec()}, 8'h00);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("regrant_after_rst", {3'b0, dut_vec()}, 8'b000_01110);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Random traffic with safety and starvation checks.
      wait0 = 0;
      wait1 = 0;
      for (int i = 0; i < 1000; i++) begin
         logic r0, r1, d;
         r0 = ($urandom_range(0, 3) != 0);
         r1 = ($urandom_range(0, 3) != 0);
         d  = ($urandom_range(0, 7) == 0);
         wait0 = (r0 && !bus.gnt0) ? wait0 + 1 : 0;
         wait1 = (r1 && !bus.gnt1) ? wait1 + 1 : 0;
         check("starve0", {7'b0, wait0 > MAX_HOLD + 1}, 8'd0);
         check("starve1", {7'b0, wait1 > MAX_HOLD + 1}, 8'd0);
         check("mutex", {7'b0, bus.gnt0 & bus.gnt1}, 8'd0);
         if (bus.busy) check("sel_match", {7'b0, bus.sel}, {7'b0, bus.gnt1});
         step(r0, r1, d, 1'b0);
      end

      check("sb_drained", 8'(sb_q.size()), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
